// File: rtl/rap_err_recover.sv
// Slice-serial exact re-add behind the RAP approximate adder.
// Reports exact sum, error flag and absolute error magnitude.
module rap_err_recover #(
  parameter int WIDTH = 16,
  parameter int WIN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   exact_sum,
  output logic             err_flag,
  output logic [WIDTH:0]   err_mag
);

  localparam int NSLICE = WIDTH / WIN;
  localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_CMP,
    S_OUT
  } state_t;

  state_t            r_st;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH:0]    r_approx;
  logic [WIDTH:0]    r_acc;
  logic              r_cy;
  logic [IW-1:0]     r_idx;

  logic [WIN-1:0]    w_a_sl;
  logic [WIN-1:0]    w_b_sl;
  logic [WIN:0]      w_sum;
  logic [WIDTH:0]    w_diff;

  assign w_a_sl = r_a[int'(r_idx)*WIN +: WIN];
  assign w_b_sl = r_b[int'(r_idx)*WIN +: WIN];
  assign w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl}
                + {{WIN{1'b0}}, r_cy};
  assign w_diff = (r_acc >= r_approx) ? (r_acc - r_approx)
                                      : (r_approx - r_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st      <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      exact_sum <= '0;
      err_flag  <= 1'b0;
      err_mag   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_approx  <= '0;
      r_acc     <= '0;
      r_cy      <= 1'b0;
      r_idx     <= '0;
    end else begin
      unique case (r_st)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_approx <= approx_sum;
            r_acc    <= '0;
            r_cy     <= 1'b0;
            r_idx    <= '0;
            in_ready <= 1'b0;
            r_st     <= S_ADD;
          end
        end
        S_ADD: begin
          r_acc[int'(r_idx)*WIN +: WIN] <= w_sum[WIN-1:0];
          r_cy <= w_sum[WIN];
          if (r_idx == LAST) begin
            r_acc[WIDTH] <= w_sum[WIN];
            r_st         <= S_CMP;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_CMP: begin
          err_flag  <= (r_acc != r_approx);
          err_mag   <= w_diff;
          exact_sum <= r_acc;
          out_valid <= 1'b1;
          r_st      <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_st      <= S_IDLE;
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rap_err_recover.sv
// Directed and randomized checks for rap_err_recover.
// Expected values come from hand vectors and a plain a+b model.
module tb_rap_err_recover;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [W:0]    approx_sum = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W:0]    exact_sum;
  logic          err_flag;
  logic [W:0]    err_mag;

  int n_cmp = 0;
  int n_bad = 0;

  rap_err_recover #(.WIDTH(16), .WIN(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_sum(approx_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .exact_sum(exact_sum), .err_flag(err_flag),
    .err_mag(err_mag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RAP-style approximation: slice carry-in guessed from
  // the generate of the previous slice's top bit only.
  function automatic logic [W:0] rap(input logic [W-1:0] x,
                                     input logic [W-1:0] y);
    logic [W:0] r;
    logic [4:0] s;
    logic       ci;
    r = '0;
    for (int i = 0; i < W/4; i++) begin
      ci = (i == 0) ? 1'b0 : (x[i*4-1] & y[i*4-1]);
      s = {1'b0, x[i*4 +: 4]} + {1'b0, y[i*4 +: 4]} + {4'd0, ci};
      r[i*4 +: 4] = s[3:0];
      if (i == W/4 - 1) r[W] = s[4];
    end
    return r;
  endfunction

  task automatic send(input logic [W-1:0] x,
                      input logic [W-1:0] y,
                      input logic [W:0] ap);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a = x;
    b = y;
    approx_sum = ap;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("out_valid_seen", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run(input string tag,
                     input logic [W-1:0] x,
                     input logic [W-1:0] y,
                     input logic [W:0] ap,
                     input logic [W:0] ex,
                     input logic fl,
                     input logic [W:0] mg,
                     input bit chk_lat,
                     input int stall);
    int lat;
    send(x, y, ap);
    a = $urandom;
    b = $urandom;
    approx_sum = 17'($urandom);
    wait_out(lat);
    if (chk_lat) chk({tag, "_lat"}, lat, 32'd6);
    chk({tag, "_exact"}, {15'd0, exact_sum}, {15'd0, ex});
    chk({tag, "_flag"}, {31'd0, err_flag}, {31'd0, fl});
    chk({tag, "_mag"}, {15'd0, err_mag}, {15'd0, mg});
    for (int i = 0; i < stall; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [W:0] hold_ex, hold_mg;
    logic       hold_fl;
    logic [W-1:0] x, y;
    logic [W:0] ap, ex, mg;
    int lat;

    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_exact", {15'd0, exact_sum}, 32'd0);
    chk("rst_mag", {15'd0, err_mag}, 32'd0);
    chk("rst_flag", {31'd0, err_flag}, 32'd0);
    rst_n = 1'b1;
    tick();

    run("t1", 16'h1234, 16'h0101, 17'h01335,
        17'h01335, 1'b0, 17'h0, 1'b1, 0);
    run("t2", 16'h00FF, 16'h0001, 17'h000C0,
        17'h00100, 1'b1, 17'h00040, 1'b1, 0);
    run("t3", 16'hFFFF, 16'h0001, 17'h0FFC0,
        17'h10000, 1'b1, 17'h00040, 1'b1, 1);
    run("t3b", 16'h0010, 16'h0020, 17'h00070,
        17'h00030, 1'b1, 17'h00040, 1'b0, 0);

    // Backpressure with a pending set on the inputs.
    send(16'hABCD, 16'h1111, 17'h0BCDE);
    wait_out(lat);
    hold_ex = exact_sum;
    hold_fl = err_flag;
    hold_mg = err_mag;
    chk("bp_exact0", {15'd0, hold_ex}, 32'h0BCDE);
    chk("bp_flag0", {31'd0, hold_fl}, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = 16'(i * 16'h0101);
      b = 16'h0F0F;
      approx_sum = 17'h0;
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_exact", {15'd0, exact_sum}, {15'd0, hold_ex});
      chk("bp_mag", {15'd0, err_mag}, {15'd0, hold_mg});
    end
    a = 16'h8000;
    b = 16'h8000;
    approx_sum = 17'h00000;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_drop", {31'd0, out_valid}, 32'd0);
    chk("bp_idle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_taken", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    chk("bp_next_exact", {15'd0, exact_sum}, 32'h10000);
    chk("bp_next_mag", {15'd0, err_mag}, 32'h10000);
    chk("bp_next_flag", {31'd0, err_flag}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the slice-2 ADD cycle.
    send(16'h7777, 16'h8888, 17'h0FFFF);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_exact", {15'd0, exact_sum}, 32'd0);
    chk("mr_mag", {15'd0, err_mag}, 32'd0);
    chk("mr_flag", {31'd0, err_flag}, 32'd0);
    tick();
    rst_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) lat++;
    end
    chk("mr_no_pulse", lat, 32'd0);
    run("mr_fresh", 16'h7777, 16'h8888, 17'h0FFFF,
        17'h0FFFF, 1'b0, 17'h0, 1'b1, 0);

    // Random sets against a plain a+b reference.
    for (int k = 0; k < 1000; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      ap = rap(x, y);
      ex = {1'b0, x} + {1'b0, y};
      mg = (ex >= ap) ? ex - ap : ap - ex;
      run("rnd", x, y, ap, ex, (ex != ap), mg, 1'b1,
          int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
